wb_sdram_arbiter: RTL and testbench
===================================

# wb_sdram_arbiter

Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller between NREQ requesters: testbench agents, a scrubber, or DMA engines. It sits between the requesters and the controller's wb_* port. It withholds grants until the controller reports SDRAM init done. It holds each grant for a whole Wishbone cycle, including bursts, and aborts a tenure whose ack never arrives, flagging it as an error.

## Interface
Parameters:
- NREQ, 2 — number of requesters, 2..8
- DW, 32 — data width
- AW, 26 — address width
- TIMEOUT, 255 — maximum cycles with stb high and no ack before abort; 1..65535

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- sdr_init_done  in  1  SDRAM controller init complete
- req_cyc_i, req_stb_i, req_we_i  in  NREQ each  per-requester Wishbone controls
- req_addr_i  in  NREQ*AW  flattened; requester k at [k*AW +: AW]
- req_dat_i  in  NREQ*DW  flattened write data
- req_sel_i  in  NREQ*DW/8  flattened byte enables
- req_cti_i  in  NREQ*3  flattened cycle type
- req_ack_o  out  NREQ  per-requester ack
- req_err_o  out  NREQ  one-cycle timeout-abort pulse
- req_dat_o  out  DW  read data, broadcast to all requesters
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  to controller
- wb_addr_o  out  AW
- wb_dat_o  out  DW
- wb_sel_o  out  DW/8
- wb_cti_o  out  3
- wb_ack_i  in  1  from controller
- wb_dat_i  in  DW  from controller
- grant_o  out  NREQ  one-hot current owner; 0 when idle
- err_cnt_o  out  16  saturating timeout-abort count

## Operation
- States: IDLE, BUSY, ABORT. An enum in the package.
- **IDLE**
  - When sdr_init_done=1 and any req_cyc_i[k]&req_stb_i[k] is set, pick the winner by round-robin and go to BUSY.
  - Search order starts at last+1 and wraps modulo NREQ.
  - `last` resets to NREQ-1, so requester 0 wins first after reset.
  - Register the winner into grant_o and last.
  - If sdr_init_done=0, grant nothing.
- **BUSY**
  - wb_cyc_o=req_cyc_i[g].
  - wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o and wb_cti_o are combinational muxes of requester g.
  - req_ack_o[g]=wb_ack_i. Every other req_ack_o bit is 0.
  - req_dat_o=wb_dat_i in all states.
  - When req_cyc_i[g]=0, go to IDLE.
  - Bursts (cti 010…111) need no special handling: the grant persists while cyc is high.
- **Timeout**
  - A 16-bit counter clears on grant and on every wb_ack_i.
  - It increments each BUSY cycle with wb_stb_o=1 and no ack.
  - When it reaches TIMEOUT: go to ABORT, pulse req_err_o[g] for one cycle, and increment err_cnt_o (saturating at 0xFFFF).
- **ABORT**
  - All wb_* outputs are 0 and req_ack_o=0. grant_o stays held.
  - Return to IDLE when req_cyc_i[g]=0.
- sdr_init_done falling during BUSY does not abort the tenure; it only blocks new grants.
- Requests from non-granted requesters are ignored. They keep waiting and see no ack.

## Timing
- Reset values: grant_o=0, all wb_* outputs 0, req_ack_o=0, req_err_o=0, err_cnt_o=0, state IDLE, last=NREQ-1. Reset is asynchronous and takes effect immediately, including mid-burst.
- Grant latency: a request sampled at edge N in IDLE gives wb_cyc_o=1 after edge N.
- The ack path is combinational: zero added latency, so throughput equals the controller's.
- Release to next grant: req_cyc_i[g] low at edge N means IDLE after N, next grant after N+1. wb_cyc_o is low for at least one cycle between tenures, even with a simultaneous pending request.
- Timeout: with stb high from cycle 1 and no ack, ABORT is entered at the edge ending cycle TIMEOUT. The req_err_o pulse and wb_cyc_o=0 are visible in the following cycle.
- Ack and timeout on the same cycle: the ack wins and the counter clears.

## Structure
- Package sdram_arb_pkg holds:
  - arb_state_t (IDLE, BUSY, ABORT)
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111
  - the ERR_CNT_W=16 constant
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs are req vector and last; outputs are one-hot grant and valid. Parameterised on NREQ.
- The top holds the FSM, timeout counter, error counter and muxes.

## Test plan
1. **Init gating.** Reset, sdr_init_done=0, req0 holds cyc/stb for 10 cycles → wb_cyc_o stays 0. Raise init_done → wb_cyc_o=1 and grant_o=01 one edge later.
2. **Round-robin.** NREQ=2, both requesters issue single reads continuously → grants alternate 01,10,01,10, with one wb_cyc_o-low cycle between each.
3. **Burst write.** Requester 1 issues 4 beats, cti 010,010,010,111, addr 0x100–0x103, data 0xA0–0xA3, while req0 also requests → four acks only on req_ack_o[1], wb_dat_o carries 0xA0–0xA3 in order, req0 is granted afterwards.
4. **Timeout.** TIMEOUT=8, the controller model never acks → req_err_o[g] pulses once after cycle 8, wb_cyc_o drops, err_cnt_o=1. Requester drops cyc → IDLE, next request is granted normally.
5. **Reset mid-burst.** Assert RESET during beat 2 of a 4-beat burst → all outputs 0 immediately. After release, with both requesting, grant_o=01.
6. **Read return.** Controller returns 0xDEADBEEF with ack to requester 0 → req_dat_o=0xDEADBEEF and req_ack_o=01 in the same cycle.

Source files
------------

// File: rtl/wb_sdram_arbiter_pkg.sv
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared types and constants for the Wishbone SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam int ERR_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/wb_sdram_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin priority encoder, search from last+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 2,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [LW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic            o_valid
);

    logic [LW-1:0] w_idx;

    // Walk the ring starting just after the previous winner; first hit wins.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_idx = LW'((int'(i_last) + off) % NREQ);
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_sdram_arbiter.sv
// ============================================================================
// Module   : wb_sdram_arbiter
// Brief    : Round-robin Wishbone arbiter in front of the SDRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sdram_arbiter #(
    parameter int NREQ    = 2,
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int TIMEOUT = 255
) (
    input  logic                 sys_clk,
    input  logic                 RESET,
    input  logic                 sdr_init_done,
    input  logic [NREQ-1:0]      req_cyc_i,
    input  logic [NREQ-1:0]      req_stb_i,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*DW-1:0]   req_dat_i,
    input  logic [NREQ*DW/8-1:0] req_sel_i,
    input  logic [NREQ*3-1:0]    req_cti_i,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [NREQ-1:0]      req_err_o,
    output logic [DW-1:0]        req_dat_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [AW-1:0]        wb_addr_o,
    output logic [DW-1:0]        wb_dat_o,
    output logic [DW/8-1:0]      wb_sel_o,
    output logic [2:0]           wb_cti_o,
    input  logic                 wb_ack_i,
    input  logic [DW-1:0]        wb_dat_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [15:0]          err_cnt_o
);

    import sdram_arb_pkg::*;

    localparam int LW = $clog2(NREQ);
    localparam int SW = DW / 8;
    localparam logic [ERR_CNT_W-1:0] C_TMO_LAST = ERR_CNT_W'(TIMEOUT - 1);
    localparam logic [ERR_CNT_W-1:0] C_CNT_MAX  = '1;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [NREQ-1:0]      r_grant;
    logic [LW-1:0]        r_last;
    logic [ERR_CNT_W-1:0] r_tmo;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [NREQ-1:0]      r_err;

    logic [AW-1:0]        w_addr [NREQ];
    logic [DW-1:0]        w_dat  [NREQ];
    logic [SW-1:0]        w_sel  [NREQ];
    logic [2:0]           w_cti  [NREQ];

    logic [NREQ-1:0]      w_req;
    logic [NREQ-1:0]      w_pick;
    logic                 w_pick_vld;
    logic [LW-1:0]        w_pick_idx;
    logic                 w_own_cyc;
    logic                 w_own_stb;
    logic                 w_grant_en;
    logic                 w_release;
    logic                 w_tmo_hit;

    generate
        for (genvar k = 0; k < NREQ; k++) begin : g_unpack
            assign w_addr[k] = req_addr_i[k*AW +: AW];
            assign w_dat[k]  = req_dat_i[k*DW +: DW];
            assign w_sel[k]  = req_sel_i[k*SW +: SW];
            assign w_cti[k]  = req_cti_i[k*3 +: 3];
        end
    endgenerate

    assign w_req = req_cyc_i & req_stb_i;

    rr_pick #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick[k]) w_pick_idx = LW'(k);
        end
    end

    // r_last doubles as the owner index while a grant is held.
    assign w_own_cyc = req_cyc_i[r_last];
    assign w_own_stb = req_stb_i[r_last];

    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_release   = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (sdr_init_done && w_pick_vld) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!w_own_cyc) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_own_stb && !wb_ack_i && (r_tmo == C_TMO_LAST)) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ABORT;
                end
            end
            ABORT: begin
                if (!w_own_cyc) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            r_grant   <= '0;
            r_last    <= LW'(NREQ - 1);
            r_tmo     <= '0;
            r_err_cnt <= '0;
            r_err     <= '0;
        end else begin
            r_err <= '0;
            if (w_grant_en) begin
                r_grant <= w_pick;
                r_last  <= w_pick_idx;
                r_tmo   <= '0;
            end else if (w_release) begin
                r_grant <= '0;
            end
            if (r_state == BUSY) begin
                if (wb_ack_i)       r_tmo <= '0;
                else if (w_own_stb) r_tmo <= r_tmo + 1'b1;
            end
            if (w_tmo_hit) begin
                r_err <= r_grant;
                if (r_err_cnt != C_CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    // Bus is driven only while a live tenure is in BUSY; ABORT parks it at zero.
    always_comb begin
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        wb_cti_o  = '0;
        req_ack_o = '0;
        if (r_state == BUSY) begin
            wb_cyc_o  = w_own_cyc;
            wb_stb_o  = w_own_stb;
            wb_we_o   = req_we_i[r_last];
            wb_addr_o = w_addr[r_last];
            wb_dat_o  = w_dat[r_last];
            wb_sel_o  = w_sel[r_last];
            wb_cti_o  = w_cti[r_last];
            req_ack_o = r_grant & {NREQ{wb_ack_i}};
        end
    end

    assign req_dat_o = wb_dat_i;
    assign grant_o   = r_grant;
    assign req_err_o = r_err;
    assign err_cnt_o = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_sdram_arbiter.sv
// ============================================================================
// Module   : tb_wb_sdram_arbiter
// Brief    : Directed + randomized bench for wb_sdram_arbiter with an owner-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_sdram_arbiter;

    import sdram_arb_pkg::*;

    localparam int NREQ    = 2;
    localparam int DW      = 32;
    localparam int AW      = 26;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 8;

    logic sys_clk = 1'b0;
    logic RESET;
    logic sdr_init_done;
    always #5 sys_clk = ~sys_clk;

    logic [NREQ-1:0]      req_cyc_i, req_stb_i, req_we_i;
    logic [AW-1:0]        a_addr [NREQ];
    logic [DW-1:0]        a_dat  [NREQ];
    logic [SW-1:0]        a_sel  [NREQ];
    logic [2:0]           a_cti  [NREQ];
    logic [NREQ*AW-1:0]   req_addr_i;
    logic [NREQ*DW-1:0]   req_dat_i;
    logic [NREQ*SW-1:0]   req_sel_i;
    logic [NREQ*3-1:0]    req_cti_i;
    logic [NREQ-1:0]      req_ack_o, req_err_o, grant_o;
    logic [DW-1:0]        req_dat_o, wb_dat_o, wb_dat_i;
    logic                 wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [AW-1:0]        wb_addr_o;
    logic [SW-1:0]        wb_sel_o;
    logic [2:0]           wb_cti_o;
    logic [15:0]          err_cnt_o;

    for (genvar k = 0; k < NREQ; k++) begin : g_pack
        assign req_addr_i[k*AW +: AW] = a_addr[k];
        assign req_dat_i[k*DW +: DW]  = a_dat[k];
        assign req_sel_i[k*SW +: SW]  = a_sel[k];
        assign req_cti_i[k*3 +: 3]    = a_cti[k];
    end

    wb_sdram_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .RESET(RESET), .sdr_init_done(sdr_init_done),
        .req_cyc_i(req_cyc_i), .req_stb_i(req_stb_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .req_cti_i(req_cti_i), .req_ack_o(req_ack_o), .req_err_o(req_err_o),
        .req_dat_o(req_dat_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
        .wb_dat_i(wb_dat_i), .grant_o(grant_o), .err_cnt_o(err_cnt_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody), whether the tenure was
    // aborted, the last winner, stalled-strobe cycles and the error tally.
    int m_owner, m_last, m_stall, m_errcnt, m_errpulse;
    bit m_abort;
    logic [NREQ-1:0] e_ack, e_err;

    task automatic m_reset();
        m_owner = -1; m_abort = 1'b0; m_last = NREQ - 1;
        m_stall = 0; m_errcnt = 0; m_errpulse = -1;
        e_ack = '0; e_err = '0;
    endtask

    task automatic compare_and_step();
        logic [NREQ-1:0] eg, ea, ee;
        logic ecyc, estb, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edat, rd;
        logic [SW-1:0] esel;
        logic [2:0] ecti;
        int k;
        eg = '0; ea = '0; ee = '0; ecyc = 0; estb = 0; ewe = 0;
        eaddr = '0; edat = '0; esel = '0; ecti = '0; rd = wb_dat_i;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (!m_abort) begin
                ecyc = req_cyc_i[m_owner]; estb = req_stb_i[m_owner]; ewe = req_we_i[m_owner];
                eaddr = a_addr[m_owner]; edat = a_dat[m_owner];
                esel = a_sel[m_owner]; ecti = a_cti[m_owner];
                ea[m_owner] = wb_ack_i;
            end
        end
        if (m_errpulse >= 0) ee[m_errpulse] = 1'b1;
        chk("grant", grant_o, eg);
        chk("ctl", {wb_cyc_o, wb_stb_o, wb_we_o}, {ecyc, estb, ewe});
        chk("addr", wb_addr_o, eaddr);
        chk("wdat", wb_dat_o, edat);
        chk("sel_cti", {wb_sel_o, wb_cti_o}, {esel, ecti});
        chk("ack", req_ack_o, ea);
        chk("err", req_err_o, ee);
        chk("err_cnt", err_cnt_o, m_errcnt[15:0]);
        chk("rdat", req_dat_o, rd);
        e_ack = ea; e_err = ee;
        m_errpulse = -1;
        if (RESET) begin
            m_reset();
        end else if (m_owner < 0) begin
            if (sdr_init_done) begin
                for (int i = 1; i <= NREQ; i++) begin
                    k = (m_last + i) % NREQ;
                    if (m_owner < 0 && req_cyc_i[k] && req_stb_i[k]) begin
                        m_owner = k; m_last = k; m_stall = 0;
                    end
                end
            end
        end else if (!req_cyc_i[m_owner]) begin
            m_owner = -1; m_abort = 1'b0;
        end else if (!m_abort) begin
            if (wb_ack_i) m_stall = 0;
            else if (req_stb_i[m_owner]) begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_abort = 1'b1; m_errpulse = m_owner;
                    if (m_errcnt < 65535) m_errcnt++;
                end
            end
        end
    endtask

    task automatic cyc_step();
        @(negedge sys_clk);
        compare_and_step();
        @(posedge sys_clk);
        #1;
    endtask

    int left [NREQ];
    int gap  [NREQ];
    int dead_cnt = 0;
    int init_low = 0;

    task automatic drive_random();
        for (int k = 0; k < NREQ; k++) begin
            if (req_cyc_i[k]) begin
                if (e_err[k]) left[k] = 0;
                else if (e_ack[k]) begin
                    left[k]--;
                    a_addr[k] = a_addr[k] + 1'b1;
                    a_dat[k]  = $urandom;
                    a_cti[k]  = (left[k] == 1) ? CTI_END : CTI_INCR;
                end
                if (left[k] == 0) begin
                    req_cyc_i[k] = 1'b0; req_stb_i[k] = 1'b0;
                    gap[k] = $urandom_range(0, 4);
                end else begin
                    req_stb_i[k] = ($urandom_range(0, 5) != 0);
                end
            end else if (gap[k] > 0) begin
                gap[k]--;
            end else begin
                left[k] = $urandom_range(1, 4);
                req_cyc_i[k] = 1'b1; req_stb_i[k] = 1'b1;
                req_we_i[k] = ($urandom_range(0, 1) == 1);
                a_addr[k] = AW'($urandom);
                a_dat[k]  = $urandom;
                a_sel[k]  = SW'($urandom);
                a_cti[k]  = (left[k] == 1) ? CTI_CLASSIC : CTI_INCR;
            end
        end
        if (dead_cnt > 0) dead_cnt--;
        else if ($urandom_range(0, 49) == 0) dead_cnt = 12;
        if (init_low > 0) init_low--;
        else if ($urandom_range(0, 79) == 0) init_low = $urandom_range(1, 10);
        sdr_init_done = (init_low == 0);
        wb_dat_i = $urandom;
        wb_ack_i = (m_owner >= 0) && !m_abort && req_cyc_i[m_owner] && req_stb_i[m_owner]
                   && (dead_cnt == 0) && ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        RESET = 1'b1; sdr_init_done = 1'b0;
        req_cyc_i = '0; req_stb_i = '0; req_we_i = '0;
        wb_ack_i = 1'b0; wb_dat_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            a_addr[k] = '0; a_dat[k] = '0; a_sel[k] = '1; a_cti[k] = CTI_CLASSIC;
            left[k] = 0; gap[k] = 0;
        end
        m_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o}, 0);
        chk("rst_ack_err", {req_ack_o, req_err_o}, 0);
        chk("rst_errcnt", err_cnt_o, 0);
        RESET = 1'b0;

        // Init gating.
        req_cyc_i[0] = 1'b1; req_stb_i[0] = 1'b1; a_addr[0] = 26'h40;
        repeat (10) cyc_step();
        chk("init_gate", wb_cyc_o, 0);
        sdr_init_done = 1'b1;
        cyc_step();
        chk("init_grant", grant_o, 2'b01);
        chk("init_cyc", wb_cyc_o, 1);

        // Read return, same-cycle ack and data.
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF;
        #1;
        chk("rd_dat", req_dat_o, 32'hDEADBEEF);
        chk("rd_ack", req_ack_o, 2'b01);
        cyc_step();
        req_cyc_i[0] = 1'b0; req_stb_i[0] = 1'b0; wb_ack_i = 1'b0;
        cyc_step();

        // Burst write from requester 1 while requester 0 waits.
        req_cyc_i = 2'b11; req_stb_i = 2'b11; req_we_i = 2'b10;
        a_addr[1] = 26'h100; a_dat[1] = 32'hA0; a_cti[1] = CTI_INCR;
        cyc_step();
        chk("burst_grant", grant_o, 2'b10);
        for (int b = 0; b < 4; b++) begin
            a_addr[1] = AW'(32'h100 + b);
            a_dat[1]  = 32'hA0 + b;
            a_cti[1]  = (b == 3) ? CTI_END : CTI_INCR;
            wb_ack_i  = 1'b1;
            #1;
            chk("burst_wdat", wb_dat_o, 32'hA0 + b);
            chk("burst_ack", req_ack_o, 2'b10);
            cyc_step();
        end
        req_cyc_i[1] = 1'b0; req_stb_i[1] = 1'b0; wb_ack_i = 1'b0;
        cyc_step();
        chk("gap_cyc", wb_cyc_o, 0);
        cyc_step();
        chk("rr_next", grant_o, 2'b01);
        req_cyc_i[0] = 1'b0; req_stb_i[0] = 1'b0;
        cyc_step();

        // Timeout abort with a silent controller.
        req_cyc_i[0] = 1'b1; req_stb_i[0] = 1'b1;
        cyc_step();
        repeat (TIMEOUT) cyc_step();
        chk("tmo_err", req_err_o, 2'b01);
        chk("tmo_cyc", wb_cyc_o, 0);
        chk("tmo_cnt", err_cnt_o, 1);
        req_cyc_i[0] = 1'b0; req_stb_i[0] = 1'b0;
        cyc_step();
        req_cyc_i[0] = 1'b1; req_stb_i[0] = 1'b1; wb_ack_i = 1'b1;
        cyc_step();
        chk("tmo_regrant", grant_o, 2'b01);
        req_cyc_i[0] = 1'b0; req_stb_i[0] = 1'b0; wb_ack_i = 1'b0;
        cyc_step();

        // Randomized traffic with stalls and init_done drop-outs.
        repeat (3000) begin
            drive_random();
            cyc_step();
        end
        req_cyc_i = '0; req_stb_i = '0; wb_ack_i = 1'b0; sdr_init_done = 1'b1;
        repeat (2) cyc_step();

        // Asynchronous reset in the middle of a burst.
        req_cyc_i[0] = 1'b1; req_stb_i[0] = 1'b1; a_cti[0] = CTI_INCR;
        cyc_step();
        wb_ack_i = 1'b1;
        cyc_step();
        RESET = 1'b1;
        m_reset();
        #1;
        chk("rstmid_wb", {wb_cyc_o, wb_stb_o, wb_addr_o}, 0);
        chk("rstmid_grant", grant_o, 0);
        chk("rstmid_ack", req_ack_o, 0);
        chk("rstmid_errcnt", err_cnt_o, 0);
        cyc_step();
        req_cyc_i = 2'b11; req_stb_i = 2'b11; wb_ack_i = 1'b0;
        RESET = 1'b0;
        cyc_step();
        chk("rstmid_rr", grant_o, 2'b01);
        cyc_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
